// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store controller
// Contents: size_e (access size encoding), state_e (controller FSM states),
//   lane_t (byte enables + lane-aligned data), misaligned_chk, lane_place.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_t;

  // The illegal size encoding is treated as misaligned so it never reaches memory.
  function automatic logic misaligned_chk(input size_e size, input logic [1:0] off);
    case (size)
      SZ_WORD: return off != 2'b00;
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Moves the low-order store payload onto its byte lanes; unused lanes are zero.
  function automatic lane_t lane_place(input size_e size, input logic [1:0] off,
                                       input logic [31:0] wdata);
    lane_t l;
    l.be   = 4'b0000;
    l.data = 32'h0;
    case (size)
      SZ_WORD: begin
        l.be   = 4'b1111;
        l.data = wdata;
      end
      SZ_HALF: begin
        l.be   = 4'b0011 << off;
        l.data = {16'h0, wdata[15:0]} << {off[1], 4'b0000};
      end
      SZ_BYTE: begin
        l.be   = 4'b0001 << off;
        l.data = {24'h0, wdata[7:0]} << {off, 3'b000};
      end
      default: begin
        l.be   = 4'b0000;
        l.data = 32'h0;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - data-memory valid/ready bus
// Signals: mem_valid/mem_ready request handshake, mem_we/mem_addr/mem_wdata/mem_be
//   request payload, mem_rvalid/mem_rdata read return.
// Modports: master (controller side), slave (memory side).
interface lsu_mem_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects and sign/zero-extends load data from a raw word
// Ports: rdata (raw memory word), offset (byte offset), size (access size),
//   uns (1 = zero-extend), result (extended load value).
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h0;
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    result = 32'h0;
    case (size)
      SZ_WORD: result = rdata;
      SZ_HALF: result = {{16{half_sel[15] & ~uns}}, half_sel};
      SZ_BYTE: result = {{24{byte_sel[7] & ~uns}}, byte_sel};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store controller
// Ports: clk, rst (sync active-high); req_valid/req_ready request handshake with
//   req_we/req_size/req_unsigned/req_addr/req_wdata; mem (data-memory bus, master);
//   rsp_valid/rsp_rdata completion; misaligned and bus_err error pulses; busy stall.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  lsu_mem_ctrl_if.master     mem,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               misaligned,
  output logic               bus_err,
  output logic               busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state, state_nx;
  logic        we_q, uns_q;
  size_e       size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [CW-1:0] cnt_q;
  logic        misaligned_q, bus_err_q;

  size_e       req_sz;
  logic        accept, bad, timeout_hit, rdata_take;
  lane_t       lane;
  logic [31:0] ext;

  assign req_sz      = size_e'(req_size);
  assign accept      = (state == IDLE) && req_valid;
  assign bad         = misaligned_chk(req_sz, req_addr[1:0]);
  assign lane        = lane_place(req_sz, req_addr[1:0], req_wdata);
  // cnt_q counts completed WAIT cycles; this is the last one allowed.
  assign timeout_hit = cnt_q == CW'(TIMEOUT - 1);
  assign rdata_take  = mem.mem_rvalid &&
                       (((state == REQ) && mem.mem_ready && !we_q) || (state == WAIT));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid && !bad) state_nx = REQ;
      REQ:  if (mem.mem_ready) state_nx = (we_q || mem.mem_rvalid) ? DONE : WAIT;
      WAIT: begin
        if (mem.mem_rvalid)   state_nx = DONE;
        else if (timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = state == IDLE;
    busy          = state != IDLE;
    mem.mem_valid = state == REQ;
    mem.mem_we    = (state == REQ) && we_q;
    rsp_valid     = state == DONE;
    rsp_rdata     = ((state == DONE) && !we_q) ? ext : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_WORD;
      off_q        <= 2'b00;
      addr_q       <= RESET_ADDR;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      rdata_q      <= 32'h0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      misaligned_q <= accept && bad;
      bus_err_q    <= (state == WAIT) && !mem.mem_rvalid && timeout_hit;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_sz;
        off_q  <= req_addr[1:0];
        // Bus-facing registers only move for accesses that will actually go out.
        if (!bad) begin
          addr_q  <= {req_addr[31:2], 2'b00};
          wdata_q <= req_we ? lane.data : 32'h0;
          be_q    <= req_we ? lane.be : 4'b1111;
        end
      end
      if (state == REQ)       cnt_q <= '0;
      else if (state == WAIT) cnt_q <= cnt_q + 1'b1;
      if (rdata_take) rdata_q <= mem.mem_rdata;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign misaligned    = misaligned_q;
  assign bus_err       = bus_err_q;

  load_extend u_load_extend (
    .rdata  (rdata_q),
    .offset (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (ext)
  );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, misaligned, bus_err, busy;
  logic [31:0] rsp_rdata;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if mif ();

  lsu_mem_ctrl #(.TIMEOUT(16), .RESET_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem          (mif),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .misaligned   (misaligned),
    .bus_err      (bus_err),
    .busy         (busy)
  );

  // Presents one request at the current negedge, lets the accept edge pass and
  // returns at the following negedge (cycle 1) with req_valid dropped.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0h want 1", req_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_chk++; if (mif.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %0h want 0", mif.mem_valid); end
    n_chk++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0h want 0", mif.mem_we); end
    n_chk++; if (mif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %08h want 00000000", mif.mem_addr); end
    n_chk++; if (mif.mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_be got %0h want 0", mif.mem_be); end
    n_chk++; if (mif.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %08h want 0", mif.mem_wdata); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
    n_chk++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %08h want 0", rsp_rdata); end
    n_chk++; if (misaligned !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0h/%0h want 0/0", misaligned, bus_err); end
  endtask

  task automatic test_sb();
    mif.mem_ready = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_1003, 32'hFFFF_FFA5);
    n_chk++; if (mif.mem_valid !== 1'b1) begin n_fail++; $display("FAIL sb_mem_valid got %0h want 1", mif.mem_valid); end
    n_chk++; if (mif.mem_we !== 1'b1) begin n_fail++; $display("FAIL sb_mem_we got %0h want 1", mif.mem_we); end
    n_chk++; if (mif.mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_mem_addr got %08h want 00001000", mif.mem_addr); end
    n_chk++; if (mif.mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_mem_be got %b want 1000", mif.mem_be); end
    n_chk++; if (mif.mem_wdata !== 32'hA500_0000) begin n_fail++; $display("FAIL sb_mem_wdata got %08h want a5000000", mif.mem_wdata); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_rsp_early got %0h want 0", rsp_valid); end
    @(negedge clk);
    mif.mem_ready = 1'b0;
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sb_rsp_valid got %0h want 1", rsp_valid); end
    n_chk++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sb_rsp_rdata got %08h want 0", rsp_rdata); end
    n_chk++; if (mif.mem_valid !== 1'b0) begin n_fail++; $display("FAIL sb_mem_valid_done got %0h want 0", mif.mem_valid); end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sb_after got rsp %0h ready %0h want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_store_lanes();
    logic [1:0]  sz;
    logic [31:0] a, wd, ewd;
    logic [3:0]  ebe;
    mif.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin sz = 2'b01; a = 32'h1002; wd = 32'h0000_BEEF; ebe = 4'b1100; ewd = 32'hBEEF_0000; end
        1:       begin sz = 2'b10; a = 32'h1001; wd = 32'h0000_0012; ebe = 4'b0010; ewd = 32'h0000_1200; end
        2:       begin sz = 2'b00; a = 32'h1004; wd = 32'hDEAD_BEEF; ebe = 4'b1111; ewd = 32'hDEAD_BEEF; end
        default: begin sz = 2'b01; a = 32'h1000; wd = 32'hFFFF_1234; ebe = 4'b0011; ewd = 32'h0000_1234; end
      endcase
      issue(1'b1, sz, 1'b0, a, wd);
      n_chk++; if (mif.mem_be !== ebe) begin n_fail++; $display("FAIL lanes_be[%0d] got %b want %b", i, mif.mem_be, ebe); end
      n_chk++; if (mif.mem_wdata !== ewd) begin n_fail++; $display("FAIL lanes_wdata[%0d] got %08h want %08h", i, mif.mem_wdata, ewd); end
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lanes_rsp[%0d] got %0h want 1", i, rsp_valid); end
      @(negedge clk);
    end
    mif.mem_ready = 1'b0;
  endtask

  task automatic test_load_extend();
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a, exp;
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h8055_AA7F;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       begin sz = 2'b10; u = 1'b0; a = 32'h6001; exp = 32'hFFFF_FFAA; end
        1:       begin sz = 2'b10; u = 1'b1; a = 32'h6001; exp = 32'h0000_00AA; end
        2:       begin sz = 2'b10; u = 1'b0; a = 32'h6000; exp = 32'h0000_007F; end
        3:       begin sz = 2'b01; u = 1'b0; a = 32'h6000; exp = 32'hFFFF_AA7F; end
        4:       begin sz = 2'b01; u = 1'b1; a = 32'h6000; exp = 32'h0000_AA7F; end
        5:       begin sz = 2'b10; u = 1'b0; a = 32'h6003; exp = 32'hFFFF_FF80; end
        default: begin sz = 2'b00; u = 1'b1; a = 32'h6000; exp = 32'h8055_AA7F; end
      endcase
      issue(1'b0, sz, u, a, 32'hFFFF_FFFF);
      n_chk++; if (mif.mem_be !== 4'b1111 || mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL ld_be_we[%0d] got %b/%0h want 1111/0", i, mif.mem_be, mif.mem_we); end
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin n_fail++; $display("FAIL ld_ext[%0d] got %0h %08h want 1 %08h", i, rsp_valid, rsp_rdata, exp); end
      @(negedge clk);
    end
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
  endtask

  task automatic test_lh_wait(input logic uns, input logic [31:0] exp);
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    issue(1'b0, 2'b01, uns, 32'h0000_2002, 32'h0);
    n_chk++; if (mif.mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lh_addr got %08h want 00002000", mif.mem_addr); end
    @(negedge clk);
    mif.mem_ready = 1'b0;
    n_chk++; if (mif.mem_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lh_wait got valid %0h busy %0h want 0 1", mif.mem_valid, busy); end
    repeat (2) @(negedge clk);
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h8001_7FFF;
    @(negedge clk);
    mif.mem_rvalid = 1'b0;
    n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin n_fail++; $display("FAIL lh_rsp uns=%0d got %0h %08h want 1 %08h", uns, rsp_valid, rsp_rdata, exp); end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lh_rsp_pulse got %0h want 0", rsp_valid); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz;
    logic [31:0] a;
    mif.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin sz = 2'b00; a = 32'h3001; end
        1:       begin sz = 2'b01; a = 32'h3003; end
        default: begin sz = 2'b11; a = 32'h3000; end
      endcase
      issue(1'b1, sz, 1'b0, a, 32'h1234_5678);
      n_chk++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse[%0d] got %0h want 1", i, misaligned); end
      n_chk++; if (mif.mem_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_idle[%0d] got valid %0h ready %0h want 0 1", i, mif.mem_valid, req_ready); end
      @(negedge clk);
      n_chk++; if (misaligned !== 1'b0 || mif.mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mis_after[%0d] got %0h %0h %0h want 0 0 0", i, misaligned, mif.mem_valid, rsp_valid); end
    end
    mif.mem_ready = 1'b0;
  endtask

  task automatic test_lw_stall();
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (mif.mem_valid !== 1'b1 || mif.mem_addr !== 32'h4000 || mif.mem_be !== 4'hF) begin n_fail++; $display("FAIL lw_hold[%0d] got %0h %08h %b want 1 00004000 1111", i, mif.mem_valid, mif.mem_addr, mif.mem_be); end
      @(negedge clk);
    end
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
    n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_rsp got %0h %08h want 1 12345678", rsp_valid, rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hit;
    int saw_rsp;
    hit = 0; saw_rsp = 0;
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5001, 32'h0);
    @(negedge clk);
    mif.mem_ready = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
      if (bus_err) begin hit = k; break; end
    end
    n_chk++; if (hit !== 16) begin n_fail++; $display("FAIL to_latency got %0d want 16", hit); end
    n_chk++; if (saw_rsp !== 0) begin n_fail++; $display("FAIL to_rsp got %0d want 0", saw_rsp); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL to_idle got %0h want 1", req_ready); end
    @(negedge clk);
    n_chk++; if (bus_err !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_pulse got %0h %0h want 0 0", bus_err, rsp_valid); end
  endtask

  task automatic test_reset_in_wait();
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b0;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_7000, 32'h0);
    @(negedge clk);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0 || mif.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_state got %0h %0h %0h want 1 0 0", req_ready, busy, mif.mem_valid); end
    n_chk++; if (mif.mem_addr !== 32'h0 || mif.mem_be !== 4'h0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstw_outs got %08h %b %08h want 0 0000 0", mif.mem_addr, mif.mem_be, rsp_rdata); end
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hCAFE_F00D;
    repeat (2) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rstw_stray got %0h %0h %0h want 0 0 0", rsp_valid, busy, bus_err); end
    end
    mif.mem_rvalid = 1'b0;
    mif.mem_ready = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_7002, 32'h0000_003C);
    n_chk++; if (mif.mem_be !== 4'b0100 || mif.mem_wdata !== 32'h003C_0000) begin n_fail++; $display("FAIL rstw_next_req got %b %08h want 0100 003c0000", mif.mem_be, mif.mem_wdata); end
    @(negedge clk);
    mif.mem_ready = 1'b0;
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstw_next_rsp got %0h want 1", rsp_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sb();
    test_store_lanes();
    test_load_extend();
    test_lh_wait(1'b0, 32'hFFFF_8001);
    test_lh_wait(1'b1, 32'h0000_8001);
    test_misaligned();
    test_lw_stall();
    test_timeout();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller sitting directly downstream of the store-data extender in the MEM stage. It accepts one memory request per handshake from the pipeline and places store data on the correct byte lanes with byte enables. It runs a valid/ready transaction with data memory and returns sign- or zero-extended load data. It flags misaligned accesses and response timeouts.

Parameters:
TIMEOUT, 16, max cycles spent waiting for mem_rvalid before raising bus_err (must be ≥1)
RESET_ADDR, 32'h0000_0000, reset value of mem_addr

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  pipeline presents a load/store request
req_ready  out  1  controller can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 half, 10 byte, 11 illegal (same encoding as store-data select)
req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  32  store data, already extended, payload in low bits
mem_valid  out  1  request to data memory
mem_ready  in  1  memory accepts request
mem_we  out  1  write strobe
mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-aligned store data
mem_be  out  4  byte enables
mem_rvalid  in  1  read data valid
mem_rdata  in  32  raw read word
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores)
misaligned  out  1  one-cycle pulse, access rejected
bus_err  out  1  one-cycle pulse, load timed out
busy  out  1  ~req_ready, used as pipeline stall

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0; mem_addr=RESET_ADDR; timeout counter 0. Reset in any state aborts the transaction with no response pulse.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid, capture we/size/unsigned/addr/wdata.
  - If misaligned (size 11; half with addr[0]=1; word with addr[1:0]≠0), pulse misaligned next cycle and stay IDLE. No memory access occurs.
  - Otherwise go to REQ.
- REQ: mem_valid=1. addr/we/wdata/be are held stable until mem_ready.
  - On mem_ready with a store → DONE.
  - On mem_ready with a load and mem_rvalid in the same cycle → capture rdata, → DONE.
  - On mem_ready with a load without mem_rvalid → WAIT, counter cleared.
- WAIT: mem_valid=0; the counter increments each cycle.
  - mem_rvalid → capture rdata, → DONE.
  - Counter reaching TIMEOUT without mem_rvalid → pulse bus_err, → IDLE, no rsp_valid.
- DONE: rsp_valid=1 for exactly one cycle, rsp_rdata valid in that cycle, → IDLE.
- Latency: store accepted at cycle 0, mem_valid at cycle 1; with mem_ready at cycle 1, rsp_valid at cycle 2. A load with same-cycle rvalid has the same latency; each WAIT cycle adds one.
- Store lanes, with off=addr[1:0]:
  - byte: wdata[7:0] on lane off, be=4'b0001<<off.
  - half: wdata[15:0] on lanes {addr[1],0}, be=4'b0011<<off.
  - word: be=4'b1111.
  - Unused lanes of mem_wdata are 0.
- Load extract: select byte/half at off from mem_rdata. Sign-extend from bit 7/15 unless req_unsigned=1, in which case zero-extend. Word passes through unchanged. mem_be=4'b1111 on loads.
- mem_rvalid outside REQ/WAIT is ignored. req_valid while busy is ignored (no capture).
- All outputs are registered or derived only from state/captured registers; there is no combinational path from req_* to mem_*.

Decomposition:
- lsu_pkg holds: size_e enum (SZ_WORD, SZ_HALF, SZ_BYTE, SZ_ILL); state_e enum (IDLE, REQ, WAIT, DONE); a misaligned-check function; a be/lane-shift function.
- One combinational sub-module, load_extend (rdata, offset, size, unsigned → 32-bit result). It is unit-testable on its own.

Test Plan:
- SB, addr 0x1003, wdata 0xFFFF_FFA5, mem_ready at first mem_valid → mem_addr 0x1000, mem_be 1000, mem_wdata 0xA500_0000, rsp_valid 2 cycles after accept.
- LH, addr 0x2002, mem_rdata 0x8001_7FFF, rvalid 3 cycles after ready → rsp_rdata 0xFFFF_8001. Same access with req_unsigned=1 → 0x0000_8001.
- SW, addr 0x3001 → misaligned pulse 1 cycle later, mem_valid never asserted, req_ready back to 1.
- LW, mem_ready held low 4 cycles → mem_valid/mem_addr/mem_be stable across all 4 cycles, completes on ready.
- LB, TIMEOUT=16, rvalid never returns → bus_err pulse 16 cycles after entering WAIT, no rsp_valid, return to IDLE.
- rst asserted while in WAIT, then rvalid arrives → all outputs 0, stray rvalid ignored, next request completes normally.
